// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer states and CPU opcode constants.
// Contents:
//   seq_state_t  frame sequencer state encoding (IDLE=0, SETTLE=1, RUN=2, DONE=3)
//   FAM_*        CPU opcode families (upper nibble of an opcode)
//   SYS_HALT     HALT operation within the SYS family
//   OP_HALT      full HALT opcode, also decoded by the CPU core
package cpu_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2, DONE = 2'd3} seq_state_t;
   localparam logic [3:0] FAM_STACK  = 4'h0;
   localparam logic [3:0] FAM_ALU    = 4'h1;
   localparam logic [3:0] FAM_MEM    = 4'h2;
   localparam logic [3:0] FAM_BRANCH = 4'h3;
   localparam logic [3:0] FAM_SYS    = 4'h4;
   localparam logic [3:0] SYS_HALT   = 4'h4;
   localparam logic [7:0] OP_HALT    = {FAM_SYS, SYS_HALT};
endpackage

// File: rtl/cpu_frame_sequencer_cycle_budget_counter.sv
// cycle_budget_counter: 16-bit run-cycle counter with terminal-count compare.
// Ports:
//   clock     system clock
//   reset     asynchronous active-low reset
//   clear     synchronous clear to 0 (wins over en)
//   en        count up by one, saturating at MAX_CYCLES-1
//   count     current cycle index
//   terminal  count == MAX_CYCLES-1
module cycle_budget_counter #(
   parameter logic [15:0] MAX_CYCLES = 16'd20000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        en,
   output logic [15:0] count,
   output logic        terminal
);
   assign terminal = count == MAX_CYCLES - 16'd1;
   always_ff @(posedge clock or negedge reset)
      if (!reset) count <= '0;
      else count <= clear ? '0 : (en && !terminal) ? count + 16'd1 : count;
endmodule

// File: rtl/cpu_frame_sequencer.sv
// cpu_frame_sequencer: runs the CPU once per frame until HALT or cycle budget.
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   enable       run gate; low aborts a run and blocks new starts
//   frame_start  single-cycle pulse per video frame
//   cpu_op       CPU's current (registered) opcode
//   overrun_clr  clears the sticky overrun flag
//   cpu_reset    active-high reset to the CPU
//   running      CPU is executing (RUN)
//   halted       frame finished, waiting for next frame (DONE)
//   overrun      sticky: budget exhausted or frame_start arrived mid-run
//   frame_count  completed frames (wrapping)
//   last_cycles  run length of the last completed frame
module cpu_frame_sequencer
   import cpu_pkg::*;
#(
   parameter logic [15:0] MAX_CYCLES    = 16'd20000,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  HALT_OP       = OP_HALT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_start,
   input  logic [7:0]  cpu_op,
   input  logic        overrun_clr,
   output logic        cpu_reset,
   output logic        running,
   output logic        halted,
   output logic        overrun,
   output logic [15:0] frame_count,
   output logic [15:0] last_cycles
);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   seq_state_t state, next_state;
   logic [3:0] settle_cnt;
   logic [15:0] cyc;
   logic terminal, halt_hit, run_done, overrun_set;
   // The opcode on the first run cycle is left over from before reset, so it is blanked.
   assign halt_hit = cyc != 16'd0 && cpu_op == HALT_OP;
   assign run_done = state == RUN && enable && (halt_hit || terminal);
   // A halt on the final budget cycle counts as a clean finish, not an overrun.
   assign overrun_set = (frame_start && (state == SETTLE || state == RUN)) || (run_done && !halt_hit);
   cycle_budget_counter #(.MAX_CYCLES(MAX_CYCLES)) u_budget (
      .clock(clock),
      .reset(reset),
      .clear(next_state != RUN),
      .en(state == RUN),
      .count(cyc),
      .terminal(terminal)
   );
   always_comb begin
      next_state = state;
      case (state)
         IDLE:   next_state = (frame_start && enable) ? SETTLE : IDLE;
         SETTLE: next_state = (settle_cnt == SETTLE_LAST) ? RUN : SETTLE;
         RUN:    next_state = !enable ? IDLE : (halt_hit || terminal) ? DONE : RUN;
         DONE:   next_state = !enable ? IDLE : frame_start ? SETTLE : DONE;
      endcase
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         cpu_reset   <= 1'b1;
         running     <= 1'b0;
         halted      <= 1'b0;
         overrun     <= 1'b0;
         frame_count <= '0;
         last_cycles <= '0;
         settle_cnt  <= '0;
      end else begin
         state      <= next_state;
         cpu_reset  <= next_state != RUN;
         running    <= next_state == RUN;
         halted     <= next_state == DONE;
         overrun    <= overrun_set || (overrun && !overrun_clr);
         settle_cnt <= (state == SETTLE && next_state == SETTLE) ? settle_cnt + 4'd1 : '0;
         if (run_done) begin
            frame_count <= frame_count + 16'd1;
            last_cycles <= halt_hit ? cyc : MAX_CYCLES;
         end
      end
endmodule

// File: tb/tb_cpu_frame_sequencer.sv
// tb_cpu_frame_sequencer: randomized scenario checks against a frame-level reference model.
module tb_cpu_frame_sequencer;
   localparam int MAXC = 100;
   logic clock = 1'b0, reset = 1'b0, enable = 1'b0, frame_start = 1'b0, overrun_clr = 1'b0;
   logic [7:0] cpu_op = 8'h00;
   logic cpu_reset, running, halted, overrun;
   logic [15:0] frame_count, last_cycles;
   int passed = 0, total = 0;
   int m_frames = 0, m_last = 0;
   bit m_over = 1'b0;

   always #5 clock = ~clock;

   cpu_frame_sequencer #(.MAX_CYCLES(16'd100), .SETTLE_CYCLES(2), .HALT_OP(8'h44)) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .frame_start(frame_start),
      .cpu_op(cpu_op),
      .overrun_clr(overrun_clr),
      .cpu_reset(cpu_reset),
      .running(running),
      .halted(halted),
      .overrun(overrun),
      .frame_count(frame_count),
      .last_cycles(last_cycles)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] rand_op();
      logic [7:0] o;
      o = 8'($urandom);
      if (o == 8'h44) o = 8'h45;
      return o;
   endfunction

   // One frame: settle, then run cycle k sees cpu_op set here; halt_at<0 or out of range means no halt.
   task automatic run_frame(input int halt_at, input bit stale, input int fs_at, input bit clr_with_fs, input string tag);
      bit budget;
      int end_k, exp_len, seen;
      budget = !(halt_at >= 1 && halt_at <= MAXC - 1);
      exp_len = budget ? MAXC : halt_at;
      end_k = budget ? MAXC - 1 : halt_at;
      enable = 1'b1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      total++;
      if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL %s settle1: cpu_reset=%b running=%b, want 1 0", tag, cpu_reset, running);
      else passed++;
      tick();
      total++;
      if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL %s settle2: cpu_reset=%b running=%b, want 1 0", tag, cpu_reset, running);
      else passed++;
      tick();
      total++;
      if (cpu_reset !== 1'b0 || running !== 1'b1 || halted !== 1'b0) $display("FAIL %s run_entry: cpu_reset=%b running=%b halted=%b, want 0 1 0", tag, cpu_reset, running, halted);
      else passed++;
      seen = 0;
      for (int k = 0; k <= end_k; k++) begin
         cpu_op = (k == halt_at || (k == 0 && stale)) ? 8'h44 : rand_op();
         frame_start = (k == fs_at);
         overrun_clr = (k == fs_at) && clr_with_fs;
         tick();
         frame_start = 1'b0;
         overrun_clr = 1'b0;
         if (k < end_k && running === 1'b1) seen++;
      end
      cpu_op = rand_op();
      m_frames = (m_frames + 1) & 16'hFFFF;
      m_last = exp_len;
      m_over = m_over | budget | (fs_at >= 0 && fs_at <= end_k);
      total++;
      if (seen != end_k) $display("FAIL %s run_length: running held %0d cycles, want %0d", tag, seen, end_k);
      else passed++;
      total++;
      if (running !== 1'b0 || halted !== 1'b1 || cpu_reset !== 1'b1) $display("FAIL %s done_state: running=%b halted=%b cpu_reset=%b, want 0 1 1", tag, running, halted, cpu_reset);
      else passed++;
      total++;
      if (last_cycles !== 16'(m_last)) $display("FAIL %s last_cycles: got %0d want %0d", tag, last_cycles, m_last);
      else passed++;
      total++;
      if (frame_count !== 16'(m_frames)) $display("FAIL %s frame_count: got %0d want %0d", tag, frame_count, m_frames);
      else passed++;
      total++;
      if (overrun !== m_over) $display("FAIL %s overrun: got %b want %b", tag, overrun, m_over);
      else passed++;
   endtask

   task automatic clear_overrun(input string tag);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      m_over = 1'b0;
      total++;
      if (overrun !== 1'b0) $display("FAIL %s overrun_clr: got %b want 0", tag, overrun);
      else passed++;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({cpu_reset, running, halted, overrun} !== 4'b1000 || frame_count !== 16'd0 || last_cycles !== 16'd0)
         $display("FAIL reset_hold: rst/run/halt/ovr=%b%b%b%b fc=%0d lc=%0d, want 1000 0 0", cpu_reset, running, halted, overrun, frame_count, last_cycles);
      else passed++;
      @(negedge clock);
      reset = 1'b1;
      tick();
      tick();
      total++;
      if ({cpu_reset, running, halted, overrun} !== 4'b1000) $display("FAIL reset_release: rst/run/halt/ovr=%b%b%b%b want 1000", cpu_reset, running, halted, overrun);
      else passed++;
   endtask

   task automatic test_halt_basic();
      run_frame(3, 1'b0, -1, 1'b0, "halt_basic");
   endtask

   task automatic test_budget();
      run_frame(-1, 1'b0, -1, 1'b0, "budget");
      clear_overrun("budget");
   endtask

   task automatic test_stale_halt();
      run_frame(5, 1'b1, -1, 1'b0, "stale_halt");
   endtask

   task automatic test_halt_final();
      run_frame(MAXC - 1, 1'b0, -1, 1'b0, "halt_final");
   endtask

   task automatic test_frame_start_mid_run();
      run_frame(8, 1'b0, 4, 1'b0, "fs_mid_run");
      clear_overrun("fs_mid_run");
      run_frame(6, 1'b0, 2, 1'b1, "set_beats_clr");
      clear_overrun("set_beats_clr");
   endtask

   task automatic test_abort();
      enable = 1'b1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      tick();
      for (int k = 0; k <= 10; k++) begin
         cpu_op = rand_op();
         enable = (k != 10);
         tick();
      end
      total++;
      if (running !== 1'b0 || cpu_reset !== 1'b1 || halted !== 1'b0) $display("FAIL abort_state: running=%b cpu_reset=%b halted=%b, want 0 1 0", running, cpu_reset, halted);
      else passed++;
      total++;
      if (frame_count !== 16'(m_frames) || last_cycles !== 16'(m_last)) $display("FAIL abort_counts: fc=%0d lc=%0d want %0d %0d", frame_count, last_cycles, m_frames, m_last);
      else passed++;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (4) tick();
      total++;
      if (running !== 1'b0 || cpu_reset !== 1'b1) $display("FAIL enable_blocks: running=%b cpu_reset=%b, want 0 1", running, cpu_reset);
      else passed++;
      enable = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         int h, f;
         h = int'($urandom_range(0, 130)) - 10;
         f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
         run_frame(h, 1'($urandom_range(0, 1)), f, 1'($urandom_range(0, 1)), "random");
         if (m_over) clear_overrun("random");
      end
   endtask

   task automatic test_async_reset();
      run_frame(-1, 1'b0, -1, 1'b0, "pre_async");
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         cpu_op = rand_op();
         tick();
      end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({cpu_reset, running, halted, overrun} !== 4'b1000 || frame_count !== 16'd0 || last_cycles !== 16'd0)
         $display("FAIL async_reset: rst/run/halt/ovr=%b%b%b%b fc=%0d lc=%0d, want 1000 0 0", cpu_reset, running, halted, overrun, frame_count, last_cycles);
      else passed++;
      m_frames = 0;
      m_last = 0;
      m_over = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      tick();
      run_frame(7, 1'b0, -1, 1'b0, "after_async");
   endtask

   initial begin
      test_reset();
      test_halt_basic();
      test_budget();
      test_stale_halt();
      test_halt_final();
      test_frame_start_mid_run();
      test_abort();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
